// File: rtl/mem_issue_queue.sv
// In-order issue queue for load/store micro-ops, upstream of the memory unit.
// Captures late operands from the CDB and issues the head with address, byte masks and shifted store data.
module mem_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int ROB_IDX_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dispatch_valid_i,
  output logic                     dispatch_ready_o,
  input  logic                     dispatch_is_store_i,
  input  logic [2:0]               dispatch_funct3_i,
  input  logic [31:0]              dispatch_pc_i,
  input  logic [31:0]              dispatch_imm_i,
  input  logic [ROB_IDX_W-1:0]     dispatch_rob_idx_i,
  input  logic                     dispatch_rs1_ready_i,
  input  logic [31:0]              dispatch_rs1_data_i,
  input  logic [ROB_IDX_W-1:0]     dispatch_rs1_tag_i,
  input  logic                     dispatch_rs2_ready_i,
  input  logic [31:0]              dispatch_rs2_data_i,
  input  logic [ROB_IDX_W-1:0]     dispatch_rs2_tag_i,
  input  logic                     cdb_valid_i,
  input  logic [ROB_IDX_W-1:0]     cdb_rob_idx_i,
  input  logic [31:0]              cdb_data_i,
  input  logic                     flush_i,
  input  logic                     issue_ready_i,
  output logic                     issue_valid_o,
  output logic                     issue_is_store_o,
  output logic [2:0]               issue_funct3_o,
  output logic [31:0]              issue_pc_o,
  output logic [ROB_IDX_W-1:0]     issue_rob_idx_o,
  output logic [31:0]              issue_addr_o,
  output logic [1:0]               issue_byte_off_o,
  output logic [3:0]               issue_rmask_o,
  output logic [3:0]               issue_wmask_o,
  output logic [31:0]              issue_wdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     is_store_q;
  logic [2:0]           funct3_q   [DEPTH];
  logic [31:0]          pc_q       [DEPTH];
  logic [31:0]          imm_q      [DEPTH];
  logic [ROB_IDX_W-1:0] rob_q      [DEPTH];
  logic [DEPTH-1:0]     rs1_rdy_q, rs2_rdy_q;
  logic [31:0]          rs1_data_q [DEPTH];
  logic [31:0]          rs2_data_q [DEPTH];
  logic [ROB_IDX_W-1:0] rs1_tag_q  [DEPTH];
  logic [ROB_IDX_W-1:0] rs2_tag_q  [DEPTH];

  logic [AW-1:0] hidx, tidx;
  logic          full, push, pop;
  logic          byp_rs1, byp_rs2;
  logic [31:0]   ea;
  logic [3:0]    base_mask, shifted_mask;

  always_comb begin
    hidx = head_q[AW-1:0];
    tidx = tail_q[AW-1:0];
    full = (hidx == tidx) && (head_q[AW] != tail_q[AW]);
    dispatch_ready_o = !full;
    issue_valid_o = valid_q[hidx] && rs1_rdy_q[hidx] && (!is_store_q[hidx] || rs2_rdy_q[hidx]);
    // Flush dominates: no push or pop is committed in a flush cycle.
    push = dispatch_valid_i && !full && !flush_i;
    pop  = issue_valid_o && issue_ready_i && !flush_i;
    head_d = pop  ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    count_o = tail_q - head_q;
    byp_rs1 = cdb_valid_i && (cdb_rob_idx_i == dispatch_rs1_tag_i);
    byp_rs2 = cdb_valid_i && (cdb_rob_idx_i == dispatch_rs2_tag_i);
  end

  always_comb begin
    ea = rs1_data_q[hidx] + imm_q[hidx];
    case (funct3_q[hidx][1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
    shifted_mask = base_mask << ea[1:0];
    issue_is_store_o = 1'b0;
    issue_funct3_o   = '0;
    issue_pc_o       = '0;
    issue_rob_idx_o  = '0;
    issue_addr_o     = '0;
    issue_byte_off_o = '0;
    issue_rmask_o    = '0;
    issue_wmask_o    = '0;
    issue_wdata_o    = '0;
    if (issue_valid_o) begin
      issue_is_store_o = is_store_q[hidx];
      issue_funct3_o   = funct3_q[hidx];
      issue_pc_o       = pc_q[hidx];
      issue_rob_idx_o  = rob_q[hidx];
      issue_addr_o     = {ea[31:2], 2'b00};
      issue_byte_off_o = ea[1:0];
      if (is_store_q[hidx]) begin
        issue_wmask_o = shifted_mask;
        issue_wdata_o = rs2_data_q[hidx] << {ea[1:0], 3'b000};
      end else begin
        issue_rmask_o = shifted_mask;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_valid_i && !rs1_rdy_q[i] && (rs1_tag_q[i] == cdb_rob_idx_i)) begin
          rs1_rdy_q[i]  <= 1'b1;
          rs1_data_q[i] <= cdb_data_i;
        end
        if (valid_q[i] && cdb_valid_i && !rs2_rdy_q[i] && (rs2_tag_q[i] == cdb_rob_idx_i)) begin
          rs2_rdy_q[i]  <= 1'b1;
          rs2_data_q[i] <= cdb_data_i;
        end
      end
      if (pop) valid_q[hidx] <= 1'b0;
      // Tail slot is never valid when push fires, so the write cannot collide with a wakeup.
      if (push) begin
        valid_q[tidx]    <= 1'b1;
        is_store_q[tidx] <= dispatch_is_store_i;
        funct3_q[tidx]   <= dispatch_funct3_i;
        pc_q[tidx]       <= dispatch_pc_i;
        imm_q[tidx]      <= dispatch_imm_i;
        rob_q[tidx]      <= dispatch_rob_idx_i;
        rs1_tag_q[tidx]  <= dispatch_rs1_tag_i;
        rs2_tag_q[tidx]  <= dispatch_rs2_tag_i;
        rs1_rdy_q[tidx]  <= dispatch_rs1_ready_i || byp_rs1;
        rs2_rdy_q[tidx]  <= dispatch_rs2_ready_i || byp_rs2;
        rs1_data_q[tidx] <= dispatch_rs1_ready_i ? dispatch_rs1_data_i : cdb_data_i;
        rs2_data_q[tidx] <= dispatch_rs2_ready_i ? dispatch_rs2_data_i : cdb_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: vector table for address/mask/data generation,
// plus hand-written sequences for CDB wakeup, full/wrap, blocked head, bypass, flush and reset.
module tb_mem_issue_queue;

  logic        clk, rst;
  logic        d_valid, d_ready, d_is_store;
  logic [2:0]  d_funct3;
  logic [31:0] d_pc, d_imm, d_rs1_data, d_rs2_data;
  logic [4:0]  d_rob, d_rs1_tag, d_rs2_tag;
  logic        d_rs1_ready, d_rs2_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush, i_ready, i_valid, i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_pc, i_addr, i_wdata;
  logic [4:0]  i_rob;
  logic [1:0]  i_off;
  logic [3:0]  i_rmask, i_wmask, cnt;

  int checks = 0;
  int failures = 0;

  mem_issue_queue #(.DEPTH(8), .ROB_IDX_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .dispatch_valid_i(d_valid), .dispatch_ready_o(d_ready),
    .dispatch_is_store_i(d_is_store), .dispatch_funct3_i(d_funct3),
    .dispatch_pc_i(d_pc), .dispatch_imm_i(d_imm), .dispatch_rob_idx_i(d_rob),
    .dispatch_rs1_ready_i(d_rs1_ready), .dispatch_rs1_data_i(d_rs1_data), .dispatch_rs1_tag_i(d_rs1_tag),
    .dispatch_rs2_ready_i(d_rs2_ready), .dispatch_rs2_data_i(d_rs2_data), .dispatch_rs2_tag_i(d_rs2_tag),
    .cdb_valid_i(cdb_valid), .cdb_rob_idx_i(cdb_tag), .cdb_data_i(cdb_data),
    .flush_i(flush), .issue_ready_i(i_ready), .issue_valid_o(i_valid),
    .issue_is_store_o(i_is_store), .issue_funct3_o(i_funct3), .issue_pc_o(i_pc),
    .issue_rob_idx_o(i_rob), .issue_addr_o(i_addr), .issue_byte_off_o(i_off),
    .issue_rmask_o(i_rmask), .issue_wmask_o(i_wmask), .issue_wdata_o(i_wdata),
    .count_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [31:0] addr;
    logic [1:0]  off;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                          input logic r1rdy, input logic [31:0] r1, input logic [4:0] t1,
                          input logic r2rdy, input logic [31:0] r2, input logic [4:0] t2,
                          input logic [31:0] imm);
    d_valid = 1'b1; d_is_store = st; d_funct3 = f3; d_rob = rob;
    d_pc = 32'h8000_0000 + {25'd0, rob, 2'b00};
    d_rs1_ready = r1rdy; d_rs1_data = r1; d_rs1_tag = t1;
    d_rs2_ready = r2rdy; d_rs2_data = r2; d_rs2_tag = t2;
    d_imm = imm;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, {28'd0, cnt}, 32'd0);
    chk({tag, "_ivalid"}, {31'd0, i_valid}, 32'd0);
    chk({tag, "_dready"}, {31'd0, d_ready}, 32'd1);
    chk({tag, "_zero_outs"}, {i_addr | i_wdata | i_pc} | {19'd0, i_rob, i_rmask, i_wmask, i_off}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'b001, 32'h0000_1000, 32'h0000_0006, 32'h0,         32'h0000_1004, 2'd2, 4'b1100, 4'b0000, 32'h0};
    vecs[1] = '{1'b1, 3'b000, 32'h0000_2000, 32'h0000_0003, 32'h0000_00AB, 32'h0000_2000, 2'd3, 4'b0000, 4'b1000, 32'hAB00_0000};
    vecs[2] = '{1'b0, 3'b010, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0,         32'h0000_00FC, 2'd0, 4'b1111, 4'b0000, 32'h0};
    vecs[3] = '{1'b1, 3'b001, 32'h0000_0007, 32'h0000_0000, 32'h1234_ABCD, 32'h0000_0004, 2'd3, 4'b0000, 4'b1000, 32'hCD00_0000};
    vecs[4] = '{1'b0, 3'b100, 32'h0000_0011, 32'h0000_0000, 32'h0,         32'h0000_0010, 2'd1, 4'b0010, 4'b0000, 32'h0};
    vecs[5] = '{1'b1, 3'b011, 32'h0000_0000, 32'h0000_0002, 32'h0000_00FF, 32'h0000_0000, 2'd2, 4'b0000, 4'b0000, 32'h00FF_0000};
    vecs[6] = '{1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0,         32'h0000_0000, 2'd1, 4'b1110, 4'b0000, 32'h0};
    vecs[7] = '{1'b1, 3'b010, 32'h0000_0040, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0050, 2'd0, 4'b0000, 4'b1111, 32'hDEAD_BEEF};

    rst = 1'b1; flush = 1'b0; i_ready = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    set_disp(1'b0, 3'b000, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 32'h0);
    d_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk_idle("reset");

    // Table vectors: dispatch, issue next cycle, popped the cycle after.
    i_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      set_disp(vecs[v].st, vecs[v].f3, 5'(v + 10), 1'b1, vecs[v].rs1, 5'd0, 1'b1, vecs[v].rs2, 5'd0, vecs[v].imm);
      chk($sformatf("v%0d_no_issue_disp_cycle", v), {31'd0, i_valid}, 32'd0);
      step();
      d_valid = 1'b0;
      chk($sformatf("v%0d_ivalid", v), {31'd0, i_valid}, 32'd1);
      chk($sformatf("v%0d_addr", v), i_addr, vecs[v].addr);
      chk($sformatf("v%0d_off", v), {30'd0, i_off}, {30'd0, vecs[v].off});
      chk($sformatf("v%0d_rmask", v), {28'd0, i_rmask}, {28'd0, vecs[v].rm});
      chk($sformatf("v%0d_wmask", v), {28'd0, i_wmask}, {28'd0, vecs[v].wm});
      chk($sformatf("v%0d_wdata", v), i_wdata, vecs[v].wd);
      chk($sformatf("v%0d_meta", v), {i_is_store, i_funct3, 19'd0, i_rob, 4'd0},
          {vecs[v].st, vecs[v].f3, 19'd0, 5'(v + 10), 4'd0});
      chk($sformatf("v%0d_pc", v), i_pc, 32'h8000_0000 + 32'((v + 10) * 4));
      step();
      chk($sformatf("v%0d_drained", v), {28'd0, cnt}, 32'd0);
    end

    // Store waiting on rs2 tag 3 from the CDB.
    set_disp(1'b1, 3'b000, 5'd9, 1'b1, 32'h0000_2000, 5'd0, 1'b0, 32'h0, 5'd3, 32'h3);
    step();
    d_valid = 1'b0;
    chk("st_wait_ivalid0", {31'd0, i_valid}, 32'd0);
    step();
    chk("st_wait_ivalid1", {31'd0, i_valid}, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'hAB;
    chk("st_cdb_same_cycle", {31'd0, i_valid}, 32'd0);
    step();
    cdb_valid = 1'b0;
    chk("st_cdb_ivalid", {31'd0, i_valid}, 32'd1);
    chk("st_cdb_wmask", {28'd0, i_wmask}, 32'h8);
    chk("st_cdb_wdata", i_wdata, 32'hAB00_0000);
    step();
    chk("st_cdb_drained", {28'd0, cnt}, 32'd0);

    // Fill to full, refused push during a pop, then 16 push/pop pairs across the wrap.
    i_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_disp(1'b0, 3'b010, 5'(k), 1'b1, 32'h100, 5'd0, 1'b1, 32'h0, 5'd0, 32'h0);
      step();
    end
    d_valid = 1'b0;
    chk("full_dready", {31'd0, d_ready}, 32'd0);
    chk("full_count", {28'd0, cnt}, 32'd8);
    set_disp(1'b0, 3'b010, 5'd20, 1'b1, 32'h100, 5'd0, 1'b1, 32'h0, 5'd0, 32'h0);
    i_ready = 1'b1;
    chk("full_pop_rob", {27'd0, i_rob}, 32'd0);
    step();
    chk("full_refused_count", {28'd0, cnt}, 32'd7);
    for (int k = 0; k < 16; k++) begin
      set_disp(1'b0, 3'b010, 5'(k + 8), 1'b1, 32'h100, 5'd0, 1'b1, 32'h0, 5'd0, 32'h0);
      chk($sformatf("wrap_rob%0d", k), {27'd0, i_rob}, 32'(k + 1));
      step();
      chk($sformatf("wrap_count%0d", k), {28'd0, cnt}, 32'd7);
    end
    d_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("drain_rob%0d", k), {27'd0, i_rob}, 32'(k + 17));
      step();
    end
    chk_idle("drain");

    // Head blocked on rs1 tag 5; younger ready entry must wait behind it.
    set_disp(1'b0, 3'b010, 5'd1, 1'b0, 32'h0, 5'd5, 1'b1, 32'h0, 5'd0, 32'h8);
    step();
    set_disp(1'b0, 3'b010, 5'd2, 1'b1, 32'h300, 5'd0, 1'b1, 32'h0, 5'd0, 32'h0);
    step();
    d_valid = 1'b0;
    chk("blk_ivalid", {31'd0, i_valid}, 32'd0);
    chk("blk_count", {28'd0, cnt}, 32'd2);
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'h200;
    chk("blk_cdb_same_cycle", {31'd0, i_valid}, 32'd0);
    step();
    cdb_valid = 1'b0;
    chk("blk_first", {i_valid, 26'd0, i_rob}, {1'b1, 26'd0, 5'd1});
    chk("blk_first_addr", i_addr, 32'h208);
    step();
    chk("blk_second", {i_valid, 26'd0, i_rob}, {1'b1, 26'd0, 5'd2});
    chk("blk_second_addr", i_addr, 32'h300);
    step();
    chk_idle("blk");

    // Dispatch bypass: CDB tag 7 in the dispatch cycle.
    set_disp(1'b0, 3'b010, 5'd4, 1'b0, 32'h0, 5'd7, 1'b1, 32'h0, 5'd0, 32'h0);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'h40;
    step();
    d_valid = 1'b0; cdb_valid = 1'b0;
    chk("byp_ivalid", {31'd0, i_valid}, 32'd1);
    chk("byp_addr", i_addr, 32'h40);
    step();
    chk("byp_drained", {28'd0, cnt}, 32'd0);

    // Flush with five queued entries and a dispatch in the flush cycle.
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_disp(1'b0, 3'b010, 5'(k), 1'b1, 32'h100, 5'd0, 1'b1, 32'h0, 5'd0, 32'h0);
      step();
    end
    chk("fl_count5", {28'd0, cnt}, 32'd5);
    set_disp(1'b0, 3'b010, 5'd30, 1'b1, 32'h500, 5'd0, 1'b1, 32'h0, 5'd0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0; d_valid = 1'b0; i_ready = 1'b1;
    chk_idle("flush");
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_dropped%0d", k), {31'd0, i_valid}, 32'd0);
    end

    // Reset mid-operation.
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_disp(1'b1, 3'b010, 5'(k), 1'b1, 32'h100, 5'd0, 1'b1, 32'h55, 5'd0, 32'h0);
      step();
    end
    d_valid = 1'b0;
    chk("rst_pre_count", {28'd0, cnt}, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
